ps2_key_decoder: RTL

Converts the raw scancode byte stream from the PS/2 receiver into snake game commands. The block sits directly downstream of the receiver. It synchronises the receiver's byte strobe into the system clock domain and tracks Set-2 prefix bytes (E0 extended, F0 break). It maps make codes to four directions plus pause and restart, filters out illegal reversals, and buffers accepted directions in a small FIFO that the game-tick logic pops once per move.

---
 rtl/ps2_key_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scancode stream to snake game commands: strobe synchroniser,
// prefix tracking, decode, reversal filter and a small direction FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_pressed,
    input  logic [7:0]        last_pressed,
    input  logic              dir_pop,
    output logic              dir_valid,
    output logic [1:0]        dir,
    output logic [ADDR_W:0]   dir_count,
    output logic              pause_pulse,
    output logic              restart_pulse,
    output logic              overflow
);

    // state    | meaning
    // ST_IDLE  | no prefix pending
    // ST_EXT   | E0 seen, next byte is an extended code
    // ST_BRK   | F0 seen, next byte is a released key (discarded)
    // ST_EXT_BRK | E0 F0 seen, next byte is a released extended key
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    localparam logic [7:0]      BYTE_EXT = 8'hE0;
    localparam logic [7:0]      BYTE_BRK = 8'hF0;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(FIFO_DEPTH);

    logic sync1_q, sync2_q, edge_q, byte_stb;
    state_t state_q, state_d;

    logic       make_vld, make_ext;
    logic       dec_dir_vld_d, dec_pause_d, dec_restart_d;
    logic [1:0] dec_dir_d;
    logic       cmd_dir_vld_q, pause_q, restart_q;
    logic [1:0] cmd_dir_q;

    logic [1:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_q, rd_q;
    logic [ADDR_W:0]   count_q;
    logic [1:0]        last_dir_q;
    logic              overflow_q;
    logic              full, empty, pop_eff, accept, push, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= key_pressed;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign byte_stb = sync2_q & ~edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_stb) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (last_pressed == BYTE_EXT)      state_d = ST_EXT;
                    else if (last_pressed == BYTE_BRK) state_d = ST_BRK;
                    else                               state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (last_pressed == BYTE_BRK)      state_d = ST_EXT_BRK;
                    else if (last_pressed == BYTE_EXT) state_d = ST_EXT;
                    else                               state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Decode outputs: the byte is quasi-static while byte_stb is high.
    always_comb begin
        make_vld      = 1'b0;
        make_ext      = 1'b0;
        dec_dir_vld_d = 1'b0;
        dec_dir_d     = 2'b00;
        dec_pause_d   = 1'b0;
        dec_restart_d = 1'b0;
        if (byte_stb && last_pressed != BYTE_EXT && last_pressed != BYTE_BRK) begin
            make_vld = (state_q == ST_IDLE) || (state_q == ST_EXT);
            make_ext = (state_q == ST_EXT);
        end
        if (make_vld) begin
            if (make_ext) begin
                unique case (last_pressed)
                    8'h75: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b00; end
                    8'h74: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b01; end
                    8'h72: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b10; end
                    8'h6B: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b11; end
                    default: ;
                endcase
            end else begin
                unique case (last_pressed)
                    8'h1D: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b00; end
                    8'h23: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b01; end
                    8'h1B: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b10; end
                    8'h1C: begin dec_dir_vld_d = 1'b1; dec_dir_d = 2'b11; end
                    8'h29: dec_pause_d   = 1'b1;
                    8'h76: dec_restart_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_dir_vld_q <= 1'b0;
            cmd_dir_q     <= 2'b00;
            pause_q       <= 1'b0;
            restart_q     <= 1'b0;
        end else begin
            cmd_dir_vld_q <= dec_dir_vld_d;
            cmd_dir_q     <= dec_dir_d;
            pause_q       <= dec_pause_d;
            restart_q     <= dec_restart_d;
        end
    end

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign pop_eff = dir_pop & ~empty;
    // Same direction is a typematic repeat; flipping bit 1 is a 180-degree turn.
    assign accept  = cmd_dir_vld_q & (cmd_dir_q != last_dir_q)
                   & (cmd_dir_q != (last_dir_q ^ 2'b10));
    assign push    = accept & (~full | pop_eff);
    assign drop    = accept & full & ~pop_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            last_dir_q <= 2'b01;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_q | drop;
            if (restart_q) begin
                wr_q       <= '0;
                rd_q       <= '0;
                count_q    <= '0;
                last_dir_q <= 2'b01;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= cmd_dir_q;
                    wr_q        <= wr_q + ADDR_W'(1);
                    last_dir_q  <= cmd_dir_q;
                end
                if (pop_eff) rd_q <= rd_q + ADDR_W'(1);
                if (push && !pop_eff)      count_q <= count_q + (ADDR_W+1)'(1);
                else if (!push && pop_eff) count_q <= count_q - (ADDR_W+1)'(1);
            end
        end
    end

    assign dir_valid     = ~empty;
    assign dir           = mem_q[rd_q];
    assign dir_count     = count_q;
    assign pause_pulse   = pause_q;
    assign restart_pulse = restart_q;
    assign overflow      = overflow_q;

endmodule
